// File: rtl/word_mux_pkg.sv
// Shared types for the word sweep multiplexer: output mode and FSM state encodings.
package word_mux_pkg;

  typedef enum logic [1:0] {
    MODE_DIRECT     = 2'b00,
    MODE_SWEEP_UP   = 2'b01,
    MODE_SWEEP_DOWN = 2'b10,
    MODE_RSVD       = 2'b11
  } mux_mode_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_SEND = 2'b01,
    S_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/word_select.sv
// Combinational packed-array indexer: picks word idx out of CHANNELS packed words.
// An index at or above CHANNELS selects zero.
module word_select #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  localparam int IDXW    = $clog2(CHANNELS)
) (
  input  logic [CHANNELS*WIDTH-1:0] d,
  input  logic [IDXW-1:0]           idx,
  output logic [WIDTH-1:0]          y
);

  // Priority-free one-hot style select over every channel.
  always_comb begin
    y = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (idx == IDXW'(i)) y = d[i*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/word_sweep_mux.sv
// Snapshots CHANNELS words on start and streams either one selected word (DIRECT)
// or all words in ascending/descending channel order (SWEEP) over valid/ready.
//
// Handshake: out_valid is high for the whole SEND state and never looks at
// out_ready; a word transfers on any rising edge where out_valid & out_ready.
// While out_ready is low, out_data and out_idx hold their value.
module word_sweep_mux
  import word_mux_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  localparam int IDXW    = $clog2(CHANNELS)
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic [CHANNELS*WIDTH-1:0] d_in,
  input  logic [IDXW-1:0]           sel,
  input  logic [1:0]                mode,
  input  logic                      start,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [IDXW-1:0]           out_idx,
  output logic                      out_valid,
  output logic                      busy,
  output logic                      done,
  output logic [1:0]                dbg_state
);

  state_e                    state, state_n;
  mux_mode_e                 mode_q;
  logic [CHANNELS*WIDTH-1:0] snap;
  logic [IDXW-1:0]           idx, start_idx;
  logic [WIDTH-1:0]          word;
  logic                      accept, xfer, last;

  assign accept = (state == S_IDLE) && start;
  assign xfer   = (state == S_SEND) && out_ready;

  // Initial index for a newly accepted request; out-of-range DIRECT sel falls back to 0.
  always_comb begin
    start_idx = '0;
    case (mux_mode_e'(mode))
      MODE_SWEEP_UP:   start_idx = '0;
      MODE_SWEEP_DOWN: start_idx = IDXW'(CHANNELS - 1);
      default:         start_idx = (32'(sel) >= CHANNELS) ? '0 : sel;
    endcase
  end

  // Final word of the request: a single word for DIRECT/RSVD, end channel for sweeps.
  always_comb begin
    last = 1'b1;
    case (mode_q)
      MODE_SWEEP_UP:   last = (idx == IDXW'(CHANNELS - 1));
      MODE_SWEEP_DOWN: last = (idx == '0);
      default:         last = 1'b1;
    endcase
  end

  // FSM state register.
  always_ff @(posedge Clk) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_n;
  end

  // FSM next-state: IDLE -> SEND on start, SEND -> DONE after last transfer, DONE lasts one cycle.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (start) state_n = S_SEND;
      S_SEND:  if (xfer && last) state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Snapshot, captured mode and index counter; sweeps never wrap since DONE follows the end channel.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      snap   <= '0;
      idx    <= '0;
      mode_q <= MODE_DIRECT;
    end else if (accept) begin
      snap   <= d_in;
      idx    <= start_idx;
      mode_q <= mux_mode_e'(mode);
    end else if (xfer && !last) begin
      if (mode_q == MODE_SWEEP_DOWN) idx <= idx - IDXW'(1);
      else                           idx <= idx + IDXW'(1);
    end
  end

  word_select #(
    .WIDTH    (WIDTH),
    .CHANNELS (CHANNELS)
  ) u_word_select (
    .d   (snap),
    .idx (idx),
    .y   (word)
  );

  assign out_valid = (state == S_SEND);
  assign out_data  = out_valid ? word : '0;
  assign out_idx   = out_valid ? idx  : '0;
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign dbg_state = state;

endmodule

// File: tb/tb_word_sweep_mux.sv
// Self-checking bench for word_sweep_mux: default 4x32 instance with a scoreboard
// on the output stream, plus a 5x8 instance for the non-power-of-two cases.
module tb_word_sweep_mux;

  localparam int WIDTH = 32;
  localparam int CH    = 4;
  localparam int IDXW  = 2;
  localparam int W     = IDXW + WIDTH;

  // ---------------- clock / reset ----------------
  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  // ---------------- 4x32 instance ----------------
  logic [CH*WIDTH-1:0] d_in;
  logic [IDXW-1:0]     sel;
  logic [1:0]          mode;
  logic                start, out_ready;
  logic [WIDTH-1:0]    out_data;
  logic [IDXW-1:0]     out_idx;
  logic                out_valid, busy, done;
  logic [1:0]          dbg_state;

  word_sweep_mux #(.WIDTH(WIDTH), .CHANNELS(CH)) dut (
    .Clk(Clk), .Reset(Reset), .d_in(d_in), .sel(sel), .mode(mode), .start(start),
    .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
    .out_valid(out_valid), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // ---------------- 5x8 instance ----------------
  logic [39:0] d5;
  logic [2:0]  sel5, out_idx5;
  logic [1:0]  mode5, dbg5;
  logic        start5, ready5, valid5, busy5, done5;
  logic [7:0]  data5;

  word_sweep_mux #(.WIDTH(8), .CHANNELS(5)) dut5 (
    .Clk(Clk), .Reset(Reset), .d_in(d5), .sel(sel5), .mode(mode5), .start(start5),
    .out_ready(ready5), .out_data(data5), .out_idx(out_idx5),
    .out_valid(valid5), .busy(busy5), .done(done5), .dbg_state(dbg5)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Every accepted word of the 4x32 instance is popped against the expected queue.
  always @(negedge Clk) begin
    if (!Reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("unexpected_xfer", 64'd1, 64'd0);
      else check("sb_word", {30'd0, out_idx, out_data}, {30'd0, exp_q.pop_front()});
    end
    if (done) done_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [WIDTH-1:0] word_of(input logic [CH*WIDTH-1:0] d, input int i);
    return d[i*WIDTH +: WIDTH];
  endfunction

  task automatic push_sweep(input logic [CH*WIDTH-1:0] d, input bit down);
    for (int i = 0; i < CH; i++) begin
      int c;
      c = down ? (CH - 1 - i) : i;
      exp_q.push_back({IDXW'(c), word_of(d, c)});
    end
  endtask

  // Pulse start for one edge with the given request; returns in cycle t+1.
  task automatic issue(input logic [1:0] m, input logic [IDXW-1:0] s);
    mode  = m;
    sel   = s;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int max_cycles);
    int k;
    k = 0;
    while (!done && k < max_cycles) begin
      tick();
      k++;
    end
    check("done_seen", {63'd0, done}, 64'd1);
  endtask

  logic [CH*WIDTH-1:0] d_base, d_alt;
  logic [WIDTH-1:0]    held;
  int                  d0;

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    int exp_idx[6];
    d_base = {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
    Reset = 1'b1; d_in = d_base; sel = '0; mode = 2'b00; start = 1'b0; out_ready = 1'b1;
    d5 = {8'h14, 8'h13, 8'h12, 8'h11, 8'h10};
    sel5 = '0; mode5 = 2'b00; start5 = 1'b0; ready5 = 1'b1;
    tick(); tick();
    check("rst_data",  {32'd0, out_data}, 64'd0);
    check("rst_idx",   {62'd0, out_idx}, 64'd0);
    check("rst_valid", {63'd0, out_valid}, 64'd0);
    check("rst_busy",  {63'd0, busy}, 64'd0);
    check("rst_done",  {63'd0, done}, 64'd0);
    Reset = 1'b0;
    tick();

    // DIRECT sel=2; start held in the DONE cycle must be ignored.
    exp_q.push_back({2'd2, 32'hCCCC0002});
    issue(2'b00, 2'd2);
    check("dir_valid", {63'd0, out_valid}, 64'd1);
    check("dir_data",  {32'd0, out_data}, 64'hCCCC0002);
    check("dir_idx",   {62'd0, out_idx}, 64'd2);
    tick();
    check("dir_done",  {63'd0, done}, 64'd1);
    check("dir_valid_off", {63'd0, out_valid}, 64'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("dir_busy_low", {63'd0, busy}, 64'd0);
    check("dir_done_one", {63'd0, done}, 64'd0);
    tick();
    check("start_in_done_ignored", {63'd0, busy}, 64'd0);

    // SWEEP_UP then SWEEP_DOWN with out_ready held high.
    for (int dir = 0; dir < 2; dir++) begin
      push_sweep(d_base, dir == 1);
      issue(dir == 1 ? 2'b10 : 2'b01, 2'd0);
      for (int i = 0; i < CH; i++) begin
        check("sweep_valid", {63'd0, out_valid}, 64'd1);
        check("sweep_idx", {62'd0, out_idx}, (dir == 1) ? 64'(CH - 1 - i) : 64'(i));
        tick();
      end
      check("sweep_done", {63'd0, done}, 64'd1);
      tick();
      check("sweep_idle", {63'd0, busy}, 64'd0);
    end

    // Backpressure: out_ready low on cycles t+2 and t+3.
    exp_idx = '{0, 1, 1, 1, 2, 3};
    push_sweep(d_base, 1'b0);
    issue(2'b01, 2'd0);
    for (int c = 1; c <= 6; c++) begin
      out_ready = (c == 2 || c == 3) ? 1'b0 : 1'b1;
      check("bp_idx", {62'd0, out_idx}, 64'(exp_idx[c-1]));
      check("bp_data", {32'd0, out_data}, {32'd0, word_of(d_base, exp_idx[c-1])});
      if (c == 2) held = out_data;
      if (c == 3 || c == 4) check("bp_hold", {32'd0, out_data}, {32'd0, held});
      tick();
    end
    out_ready = 1'b1;
    check("bp_done_t7", {63'd0, done}, 64'd1);
    tick();

    // Snapshot isolation and start while busy.
    d_alt = {$urandom(), $urandom(), $urandom(), $urandom()};
    d_in = d_base;
    push_sweep(d_base, 1'b0);
    d0 = done_cnt;
    issue(2'b01, 2'd0);
    d_in = d_alt; mode = 2'b00; sel = 2'd3; start = 1'b1;
    tick(); tick();
    start = 1'b0;
    wait_done(20);
    tick(); tick(); tick();
    check("busy_start_one_done", 64'(done_cnt - d0), 64'd1);
    check("busy_start_idle", {63'd0, busy}, 64'd0);
    check("snap_q_empty", 64'(exp_q.size()), 64'd0);

    // Reset on the second word of a sweep, then a normal sweep.
    d_in = d_base;
    push_sweep(d_base, 1'b0);
    issue(2'b01, 2'd0);
    tick();
    check("rst_mid_idx", {62'd0, out_idx}, 64'd1);
    Reset = 1'b1;
    tick();
    check("rst_mid_valid", {63'd0, out_valid}, 64'd0);
    check("rst_mid_data",  {32'd0, out_data}, 64'd0);
    check("rst_mid_idx0",  {62'd0, out_idx}, 64'd0);
    check("rst_mid_busy",  {63'd0, busy}, 64'd0);
    exp_q.delete();
    Reset = 1'b0;
    d_in = {$urandom(), $urandom(), $urandom(), $urandom()};
    push_sweep(d_in, 1'b0);
    issue(2'b01, 2'd0);
    wait_done(20);
    tick();
    check("post_rst_q_empty", 64'(exp_q.size()), 64'd0);

    // 5x8 instance: out-of-range sel, reserved mode, descending start.
    sel5 = 3'd7; mode5 = 2'b00; start5 = 1'b1;
    tick();
    start5 = 1'b0;
    check("c5_oor_idx",  {61'd0, out_idx5}, 64'd0);
    check("c5_oor_data", {56'd0, data5}, 64'h10);
    tick();
    check("c5_oor_done", {63'd0, done5}, 64'd1);
    tick();
    sel5 = 3'd3; mode5 = 2'b11; start5 = 1'b1;
    tick();
    start5 = 1'b0;
    check("c5_rsvd_idx",  {61'd0, out_idx5}, 64'd3);
    check("c5_rsvd_data", {56'd0, data5}, 64'h13);
    tick();
    check("c5_rsvd_done", {63'd0, done5}, 64'd1);
    tick();
    mode5 = 2'b10; start5 = 1'b1;
    tick();
    start5 = 1'b0;
    check("c5_down_idx",  {61'd0, out_idx5}, 64'd4);
    check("c5_down_data", {56'd0, data5}, 64'h14);
    for (int i = 0; i < 5; i++) tick();
    check("c5_down_done", {63'd0, done5}, 64'd1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
